// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern recognizer: mode encodings
// and default widths used by the top level and the bench.
package pattern_pkg;

    // Default geometry
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    // Match-window behaviour after a hit
    localparam bit OVERLAP_OFF = 1'b0;  // window restarts, no shared bits
    localparam bit OVERLAP_ON  = 1'b1;  // sliding window, matches may overlap

    // Output timing
    localparam bit MODE_MEALY = 1'b0;   // out follows hit in the same cycle
    localparam bit MODE_MOORE = 1'b1;   // out is hit delayed by one register

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a clear
// input that takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count hits, hold at all-ones, clear wins over increment
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pattern_recognizer.sv
// Serial bit-pattern recognizer. Bits arrive MSB-of-pattern first on 'in'
// while 'en' is high; 'out' flags each completed match (Mealy or Moore
// timing) and 'match_cnt' counts matches with saturation. The pattern can
// be replaced at run time with pat_load, which also discards the window.
module pattern_recognizer
    import pattern_pkg::*;
#(
    parameter int             PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = OVERLAP_ON,
    parameter bit             MOORE   = MODE_MEALY,
    parameter int             CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // fill spans 0..PAT_W inclusive
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  r_pat;
    // The oldest of the PAT_W history bits is shifted out before it is ever
    // compared, so only the newest PAT_W-1 bits are kept.
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_out;

    logic [PAT_W-1:0]  w_window;
    logic              w_hit;

    // Candidate window: stored history followed by the bit arriving now
    assign w_window = {r_hist, in};

    // A hit needs an accepted bit, no pattern reload, and enough valid history
    assign w_hit = en & ~pat_load & (r_fill >= FILL_ARM) & (w_window == r_pat);

    // Pattern, history and fill bookkeeping
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; reset here is synchronous (checked inside the
    // clocked block), so reset=0 only takes effect at a rising clk edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= w_window[PAT_W-2:0];
            if (!OVERLAP && w_hit) begin
                r_fill <= '0;
            end else if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    // Registered copy of hit for Moore timing
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_hit;
        end
    end

    // Mealy output is masked while reset is held low
    assign out = MOORE ? r_out : (w_hit & reset);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit),
        .clr   (clr_cnt),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_pattern_recognizer.sv
// Bench for pattern_recognizer. Four instances share one stimulus stream:
//   0: overlap, Mealy, 8-bit count   1: no overlap, Mealy, 8-bit count
//   2: overlap, Moore, 8-bit count   3: overlap, Mealy, 2-bit count
// The driver pushes the expected per-cycle outputs into a queue from a
// reference model that tracks the bits seen since the window last
// restarted; a monitor pops and compares them each cycle.
module tb_pattern_recognizer;
    import pattern_pkg::*;

    localparam int         PW   = 4;
    localparam logic [3:0] PAT0 = 4'b1011;
    localparam int         NCFG = 4;

    typedef struct packed {
        logic [NCFG-1:0]      o;
        logic [NCFG-1:0][7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr_cnt = 1'b0;

    logic       out_a, out_b, out_c, out_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    logic [NCFG-1:0]      dut_o;
    logic [NCFG-1:0][7:0] dut_c;

    always #5 clk = ~clk;

    pattern_recognizer #(.PAT_W(PW), .PATTERN(PAT0), .OVERLAP(OVERLAP_ON),
                         .MOORE(MODE_MEALY), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a));

    pattern_recognizer #(.PAT_W(PW), .PATTERN(PAT0), .OVERLAP(OVERLAP_OFF),
                         .MOORE(MODE_MEALY), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b));

    pattern_recognizer #(.PAT_W(PW), .PATTERN(PAT0), .OVERLAP(OVERLAP_ON),
                         .MOORE(MODE_MOORE), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_c), .match_cnt(cnt_c));

    pattern_recognizer #(.PAT_W(PW), .PATTERN(PAT0), .OVERLAP(OVERLAP_ON),
                         .MOORE(MODE_MEALY), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .en(en), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .out(out_d), .match_cnt(cnt_d));

    assign dut_o    = {out_d, out_c, out_b, out_a};
    assign dut_c[0] = cnt_a;
    assign dut_c[1] = cnt_b;
    assign dut_c[2] = cnt_c;
    assign dut_c[3] = {6'b0, cnt_d};

    // Per-instance configuration seen by the reference model
    bit ovl  [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit moo  [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cmax [NCFG] = '{255, 255, 255, 3};

    // Reference model state
    bit         seen_q  [NCFG][$];   // bits received since the window restarted
    int         cnt_m   [NCFG] = '{0, 0, 0, 0};
    bit         moore_m [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] pat_m = PAT0;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, advance the model
    task automatic step(input logic r, input logic e, input logic b,
                        input logic pl, input logic [3:0] pi, input logic cl);
        exp_t x;
        bit   hits [NCFG];
        @(negedge clk);
        reset = r; en = e; din = b; pat_load = pl; pat_in = pi; clr_cnt = cl;
        x = '0;
        for (int k = 0; k < NCFG; k++) begin
            int sz;
            int win;
            sz = seen_q[k].size();
            hits[k] = 1'b0;
            if (e && !pl && sz >= PW - 1) begin
                win = 0;
                for (int j = sz - (PW - 1); j < sz; j++) win = win * 2 + int'(seen_q[k][j]);
                win = win * 2 + int'(b);
                hits[k] = (win == int'(pat_m));
            end
            x.o[k] = moo[k] ? moore_m[k] : (r & hits[k]);
            x.c[k] = 8'(cnt_m[k]);
        end
        exp_q.push_back(x);
        for (int k = 0; k < NCFG; k++) begin
            if (!r) begin
                seen_q[k].delete();
                cnt_m[k]   = 0;
                moore_m[k] = 1'b0;
            end else begin
                if (pl) begin
                    seen_q[k].delete();
                end else if (e) begin
                    seen_q[k].push_back(b);
                    if (hits[k] && !ovl[k]) seen_q[k].delete();
                    while (seen_q[k].size() > PW - 1) void'(seen_q[k].pop_front());
                end
                if (cl) cnt_m[k] = 0;
                else if (hits[k] && cnt_m[k] < cmax[k]) cnt_m[k] = cnt_m[k] + 1;
                moore_m[k] = hits[k];
            end
        end
        if (!r) pat_m = PAT0;
        else if (pl) pat_m = pi;
    endtask

    // Send n bits with en=1, MSB first
    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    // Monitor: compare DUT outputs with the next expected entry every cycle
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin : cmp
            exp_t x;
            x = exp_q.pop_front();
            for (int k = 0; k < NCFG; k++) begin
                check($sformatf("out%0d cyc%0d", k, cyc), int'(dut_o[k]), int'(x.o[k]));
                check($sformatf("cnt%0d cyc%0d", k, cyc), int'(dut_c[k]), int'(x.c[k]));
            end
            cyc++;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "time limit reached");
    end

    initial begin
        do_reset();
        do_reset();

        // Basic stream 1011011: two overlapping matches
        send(32'b1011011, 7);
        idle();
        #3;
        check("basic cnt overlap", int'(cnt_a), 2);
        check("basic cnt no-overlap", int'(cnt_b), 1);
        check("basic cnt moore", int'(cnt_c), 2);
        check("basic cnt narrow", int'(cnt_d), 2);

        // en gaps between bits 2 and 3 do not disturb the window
        do_reset();
        send(32'b10, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 1'b0);
        send(32'b11, 2);
        idle();
        #3;
        check("en gap cnt", int'(cnt_a), 1);

        // Runtime pattern load discards partial history
        do_reset();
        send(32'b10, 2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        send(32'b0110, 4);
        idle();
        #3;
        check("pat_load cnt", int'(cnt_a), 1);

        // Five overlapping matches saturate the 2-bit counter
        do_reset();
        send(32'b1011011011011011, 16);
        idle();
        #3;
        check("sat wide cnt", int'(cnt_a), 5);
        check("sat narrow cnt", int'(cnt_d), 3);

        // Clear on the same edge as a hit leaves zero
        send(32'b101, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        idle();
        #3;
        check("clr beats hit", int'(cnt_a), 0);

        // Mid-stream reset loses the partial window; reset masks a completing bit
        send(32'b10, 2);
        do_reset();
        send(32'b11, 2);
        send(32'b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        send(32'b1011, 4);
        idle();
        #3;
        check("reset window cnt", int'(cnt_a), 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r, e, b, pl, cl;
            logic [3:0] pi;
            r  = ($urandom_range(0, 99) >= 2);
            e  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            pl = ($urandom_range(0, 99) < 3);
            cl = ($urandom_range(0, 99) < 3);
            pi = 4'($urandom_range(0, 15));
            step(r, e, b, pl, pi, cl);
        end
        idle();

        @(negedge clk);
        #4;
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_recognizer.md
PATTERN_RECOGNIZER -- requirements
Module: pattern_recognizer

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011 (PAT_W bits), meaning reset-time pattern; MSB is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed, 0 = window restarts after a match.
REQ-004 SHALL have parameter MOORE, default 0, meaning 0 = Mealy output, 1 = Moore (registered) output.
REQ-005 SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-low reset; the block resets when reset is 0 at a rising clk edge.
REQ-008 SHALL have port en  input  1  in is sampled only when en=1.
REQ-009 SHALL have port in  input  1  serial data bit.
REQ-010 SHALL have port pat_load  input  1  loads pat_in as the new pattern.
REQ-011 SHALL have port pat_in  input  PAT_W  runtime pattern value.
REQ-012 SHALL have port clr_cnt  input  1  clears match_cnt.
REQ-013 SHALL have port out  output  1  match indication.
REQ-014 SHALL have port match_cnt  output  CNT_W  number of matches since reset or clear.

Function
REQ-015 SHALL hold pat (PAT_W), hist (PAT_W-bit shift history) and fill (0..PAT_W, count of valid history bits).
REQ-016 SHALL define hit = en & ~pat_load & (fill >= PAT_W-1) & ({hist[PAT_W-2:0], in} == pat).
REQ-017 SHALL, on an edge with en=1 and pat_load=0, shift hist <= {hist[PAT_W-2:0], in} and set fill <= min(fill+1, PAT_W).
REQ-018 SHALL, when OVERLAP=0 and hit=1, set fill <= 0 instead, so that no bit is shared between two matches.
REQ-019 SHALL leave hist and fill unchanged on edges with en=0.
REQ-020 SHALL, when MOORE=0, drive out = hit combinationally in the same cycle as the completing bit, with zero latency.
REQ-021 SHALL, when MOORE=1, register hit into out; out is asserted for exactly one cycle, one cycle after the completing bit.
REQ-022 SHALL, on an edge with pat_load=1, set pat <= pat_in and fill <= 0; en is ignored that cycle and hit=0.
REQ-023 SHALL increment match_cnt on each edge with hit=1, and SHALL saturate it at 2^CNT_W-1 with no wrap.
REQ-024 SHALL give clr_cnt priority over increment: clr_cnt=1 with hit=1 yields match_cnt=0 on that edge.
REQ-025 SHALL allow pat_load and clr_cnt to act independently in the same cycle.

Reset
REQ-026 SHALL, on an edge with reset=0, set pat <= PATTERN, hist <= 0, fill <= 0, match_cnt <= 0 and the Moore out register to 0, overriding all other inputs.
REQ-027 SHALL force Mealy out to 0 while reset=0.
REQ-028 SHALL require a full PAT_W bits after a mid-stream reset before any match; a partial window is lost.

Structure
REQ-029 SHALL place the mode encodings (OVERLAP_ON/OFF, MODE_MEALY/MOORE) and the default PAT_W/CNT_W in a shared package, pattern_pkg.
REQ-030 SHALL implement the saturating counter as sub-module sat_counter (parameter W; ports clk, reset, inc, clr, q).

Verification
REQ-031 SHALL cover: PAT_W=4, PATTERN=1011, OVERLAP=1, MOORE=0; stream 1,0,1,1,0,1,1 with en=1 -> out=1 on bits 4 and 7, match_cnt=2.
REQ-032 SHALL cover: same stream with OVERLAP=0 -> out=1 on bit 4 only, match_cnt=1.
REQ-033 SHALL cover: MOORE=1 with the same stream -> out high for one cycle in the cycles after bits 4 and 7; never high on those bits themselves.
REQ-034 SHALL cover: en=0 for 3 cycles inserted between bits 2 and 3 -> match still on bit 4, and no output change while en=0.
REQ-035 SHALL cover: pat_load with pat_in=0110 after 2 bits, then stream 0,1,1,0 -> match on the 4th new bit; old partial history discarded.
REQ-036 SHALL cover: CNT_W=2 with 5 matches -> match_cnt stops at 3; reset=0 after bit 2 of a pattern -> no match until a full new window is received.
